// File: rtl/hazard_info_pipe_pkg.sv
// rtl/hazard_info_pipe_pkg.sv - register-number width and Tnew encodings shared with decoder and stall controller
package hazard_info_pipe_pkg;

  localparam int REG_W  = 5;
  localparam int TNEW_W = 3;

  typedef enum logic [TNEW_W-1:0] {
    TNEW_ZERO = 3'd0,
    TNEW_ALU  = 3'd1,
    TNEW_LOAD = 3'd2
  } tnew_e;

endpackage

// File: rtl/hazard_stage_reg.sv
// rtl/hazard_stage_reg.sv - one pipeline register of {A1,A2,A3,WE,Tnew} with synchronous clear
// WE is stored only for a nonzero destination, so $0 writes never propagate.
module hazard_stage_reg
  import hazard_info_pipe_pkg::*;
#(
  parameter int TW = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [REG_W-1:0] a1_i,
  input  logic [REG_W-1:0] a2_i,
  input  logic [REG_W-1:0] a3_i,
  input  logic             we_i,
  input  logic [TW-1:0]    tnew_i,
  output logic [REG_W-1:0] a1_o,
  output logic [REG_W-1:0] a2_o,
  output logic [REG_W-1:0] a3_o,
  output logic             we_o,
  output logic [TW-1:0]    tnew_o
);

  logic [REG_W-1:0] a1_d, a1_q;
  logic [REG_W-1:0] a2_d, a2_q;
  logic [REG_W-1:0] a3_d, a3_q;
  logic             we_d, we_q;
  logic [TW-1:0]    tnew_d, tnew_q;

  always_comb begin
    a1_d   = '0;
    a2_d   = '0;
    a3_d   = '0;
    we_d   = 1'b0;
    tnew_d = '0;
    if (!clr) begin
      a1_d   = a1_i;
      a2_d   = a2_i;
      a3_d   = a3_i;
      we_d   = we_i && (a3_i != '0);
      tnew_d = tnew_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a1_q   <= '0;
      a2_q   <= '0;
      a3_q   <= '0;
      we_q   <= 1'b0;
      tnew_q <= '0;
    end else begin
      a1_q   <= a1_d;
      a2_q   <= a2_d;
      a3_q   <= a3_d;
      we_q   <= we_d;
      tnew_q <= tnew_d;
    end
  end

  assign a1_o   = a1_q;
  assign a2_o   = a2_q;
  assign a3_o   = a3_q;
  assign we_o   = we_q;
  assign tnew_o = tnew_q;

endmodule

// File: rtl/hazard_info_pipe.sv
// rtl/hazard_info_pipe.sv - D->E->M->W register-usage/Tnew pipe for the stall controller; HAZARD_STATS_EN adds StallCnt
module hazard_info_pipe
  import hazard_info_pipe_pkg::*;
#(
  parameter int TNEW_W = hazard_info_pipe_pkg::TNEW_W
`ifdef HAZARD_STATS_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  A1D,
  input  logic [REG_W-1:0]  A2D,
  input  logic [REG_W-1:0]  A3D,
  input  logic              WED,
  input  logic [TNEW_W-1:0] TnewD,
  input  logic              Stall,
  output logic [REG_W-1:0]  A1E,
  output logic [REG_W-1:0]  A2E,
  output logic [REG_W-1:0]  A3E,
  output logic              WEE,
  output logic [TNEW_W-1:0] TnewE,
  output logic [REG_W-1:0]  A2M,
  output logic [REG_W-1:0]  A3M,
  output logic              WEM,
  output logic [TNEW_W-1:0] TnewM,
  output logic [REG_W-1:0]  A3W,
  output logic              WEW,
  output logic              EnPC,
  output logic              EnFD,
  output logic              ClrDE
`ifdef HAZARD_STATS_EN
  , output logic [CNT_W-1:0] StallCnt
`endif
);

  logic [TNEW_W-1:0] tnew_aged;
  logic [REG_W-1:0]  a1_m, a1_w, a2_w;
  logic              we_w_unused;
  logic [TNEW_W-1:0] tnew_w;
  logic              unused_fields;

  assign EnPC  = ~Stall;
  assign EnFD  = ~Stall;
  assign ClrDE = Stall;

  // Result becomes one cycle closer each stage; never wraps below zero.
  assign tnew_aged = (TnewE == '0) ? '0 : TnewE - TNEW_W'(1);

  hazard_stage_reg #(.TW(TNEW_W)) u_de (
    .clk(clk), .rst(reset), .clr(Stall),
    .a1_i(A1D), .a2_i(A2D), .a3_i(A3D), .we_i(WED), .tnew_i(TnewD),
    .a1_o(A1E), .a2_o(A2E), .a3_o(A3E), .we_o(WEE), .tnew_o(TnewE)
  );

  hazard_stage_reg #(.TW(TNEW_W)) u_em (
    .clk(clk), .rst(reset), .clr(1'b0),
    .a1_i(A1E), .a2_i(A2E), .a3_i(A3E), .we_i(WEE), .tnew_i(tnew_aged),
    .a1_o(a1_m), .a2_o(A2M), .a3_o(A3M), .we_o(WEM), .tnew_o(TnewM)
  );

  hazard_stage_reg #(.TW(TNEW_W)) u_mw (
    .clk(clk), .rst(reset), .clr(1'b0),
    .a1_i(a1_m), .a2_i(A2M), .a3_i(A3M), .we_i(WEM), .tnew_i(TnewM),
    .a1_o(a1_w), .a2_o(a2_w), .a3_o(A3W), .we_o(we_w_unused), .tnew_o(tnew_w)
  );

  assign WEW           = we_w_unused;
  assign unused_fields = ^{a1_w, a2_w, tnew_w};

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (Stall) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign StallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_info_pipe.sv
// tb/tb_hazard_info_pipe.sv - random + directed bench for hazard_info_pipe against a history-based model
module tb_hazard_info_pipe;

  localparam int TW    = 3;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] A1D, A2D, A3D;
  logic WED;
  logic [TW-1:0] TnewD;
  logic Stall;
  logic [4:0] A1E, A2E, A3E, A2M, A3M, A3W;
  logic WEE, WEM, WEW, EnPC, EnFD, ClrDE;
  logic [TW-1:0] TnewE, TnewM;
`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] StallCnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] a1, a2, a3;
    logic       we;
    int         tnew;
  } rec_t;

  // hist[0] entered E at the last edge, hist[1] is one stage older, etc.
  rec_t hist[$];
  int   stall_cnt;

  always #5 clk = ~clk;

  hazard_info_pipe #(
    .TNEW_W(TW)
`ifdef HAZARD_STATS_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .A1D(A1D), .A2D(A2D), .A3D(A3D), .WED(WED), .TnewD(TnewD), .Stall(Stall),
    .A1E(A1E), .A2E(A2E), .A3E(A3E), .WEE(WEE), .TnewE(TnewE),
    .A2M(A2M), .A3M(A3M), .WEM(WEM), .TnewM(TnewM),
    .A3W(A3W), .WEW(WEW),
    .EnPC(EnPC), .EnFD(EnFD), .ClrDE(ClrDE)
`ifdef HAZARD_STATS_EN
    , .StallCnt(StallCnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    rec_t z;
    z.a1 = '0; z.a2 = '0; z.a3 = '0; z.we = 1'b0; z.tnew = 0;
    hist = {};
    repeat (3) hist.push_back(z);
    stall_cnt = 0;
  endtask

  task automatic step();
    rec_t r;
    @(posedge clk);
    if (!reset) begin
      if (Stall) begin
        r.a1 = '0; r.a2 = '0; r.a3 = '0; r.we = 1'b0; r.tnew = 0;
        stall_cnt++;
      end else begin
        r.a1 = A1D; r.a2 = A2D; r.a3 = A3D;
        r.we = WED && (A3D != 0);
        r.tnew = int'(TnewD);
      end
      hist.push_front(r);
      void'(hist.pop_back());
    end
    #1;
  endtask

  task automatic set_d(input int a1, input int a2, input int a3, input bit we, input int tn);
    A1D = 5'(a1); A2D = 5'(a2); A3D = 5'(a3); WED = we; TnewD = TW'(tn);
  endtask

  always @(negedge clk) begin
    rec_t e, m, w;
    e = hist[0]; m = hist[1]; w = hist[2];
    chk("A1E", 32'(A1E), 32'(e.a1));
    chk("A2E", 32'(A2E), 32'(e.a2));
    chk("A3E", 32'(A3E), 32'(e.a3));
    chk("WEE", 32'(WEE), 32'(e.we));
    chk("TnewE", 32'(TnewE), 32'(e.tnew));
    chk("A2M", 32'(A2M), 32'(m.a2));
    chk("A3M", 32'(A3M), 32'(m.a3));
    chk("WEM", 32'(WEM), 32'(m.we));
    chk("TnewM", 32'(TnewM), 32'((m.tnew > 0) ? m.tnew - 1 : 0));
    chk("A3W", 32'(A3W), 32'(w.a3));
    chk("WEW", 32'(WEW), 32'(w.we));
    chk("EnPC", 32'(EnPC), 32'(!Stall));
    chk("EnFD", 32'(EnFD), 32'(!Stall));
    chk("ClrDE", 32'(ClrDE), 32'(Stall));
`ifdef HAZARD_STATS_EN
    chk("StallCnt", 32'(StallCnt), 32'(stall_cnt % (1 << CNT_W)));
`endif
  end

  initial begin
    clear_model();
    reset = 1'b1;
    Stall = 1'b0;
    set_d(3, 4, 5, 1'b1, 2);
    step(); step();
    chk("rst_A3E", 32'(A3E), 0);
    chk("rst_WEE", 32'(WEE), 0);
    chk("rst_TnewE", 32'(TnewE), 0);
    chk("rst_A3W", 32'(A3W), 0);
    chk("rst_WEW", 32'(WEW), 0);

    reset = 1'b0;
    step();
    chk("e1_A3E", 32'(A3E), 5);
    chk("e1_WEE", 32'(WEE), 1);
    chk("e1_TnewE", 32'(TnewE), 2);
    set_d(1, 2, 0, 1'b1, 1);
    step();
    chk("e2_A3M", 32'(A3M), 5);
    chk("e2_TnewM", 32'(TnewM), 1);
    chk("zero_WEE", 32'(WEE), 0);
    set_d(6, 7, 8, 1'b1, 2);
    Stall = 1'b1;
    #1;
    chk("stall_EnPC", 32'(EnPC), 0);
    chk("stall_EnFD", 32'(EnFD), 0);
    chk("stall_ClrDE", 32'(ClrDE), 1);
    step();
    chk("e3_A3W", 32'(A3W), 5);
    chk("e3_WEW", 32'(WEW), 1);
    chk("bub1_WEE", 32'(WEE), 0);
    chk("bub1_A3E", 32'(A3E), 0);
    chk("zero_WEM", 32'(WEM), 0);
    step();
    chk("bub2_WEE", 32'(WEE), 0);
    chk("zero_WEW", 32'(WEW), 0);
    chk("bub1_A3M", 32'(A3M), 0);
    Stall = 1'b0;
    step();
    chk("load_A3E", 32'(A3E), 8);
    chk("load_TnewE", 32'(TnewE), 2);
    set_d(0, 0, 31, 1'b1, 0);
    step();
    chk("jal_A3E", 32'(A3E), 31);
    chk("jal_TnewE", 32'(TnewE), 0);
    set_d(2, 3, 9, 1'b1, 1);
    step();
    chk("jal_A3M", 32'(A3M), 31);
    chk("jal_TnewM", 32'(TnewM), 0);
    chk("jal_WEM", 32'(WEM), 1);
    step();
    reset = 1'b1;
    clear_model();
    #1;
    chk("mid_A3E", 32'(A3E), 0);
    chk("mid_A3M", 32'(A3M), 0);
    chk("mid_A3W", 32'(A3W), 0);
    chk("mid_WEW", 32'(WEW), 0);
    chk("mid_TnewE", 32'(TnewE), 0);
    chk("mid_EnPC", 32'(EnPC), 1);
    Stall = 1'b1;
    #1;
    chk("mid_ClrDE", 32'(ClrDE), 1);
    Stall = 1'b0;
    step();
    reset = 1'b0;
    set_d(1, 1, 12, 1'b1, 1);
    step();
    chk("post_A3E", 32'(A3E), 12);

`ifdef HAZARD_STATS_EN
    reset = 1'b1;
    clear_model();
    step();
    reset = 1'b0;
    Stall = 1'b1;
    repeat (17) step();
    chk("wrap_StallCnt", 32'(StallCnt), 1);
    Stall = 1'b0;
    reset = 1'b1;
    clear_model();
    #1;
    chk("rst_StallCnt", 32'(StallCnt), 0);
    step();
    reset = 1'b0;
`endif

    for (int i = 0; i < 400; i++) begin
      set_d(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 31)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
      Stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b1;
        clear_model();
        step();
        reset = 1'b0;
      end else begin
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_info_pipe.md
# hazard_info_pipe

Producer of the register-usage and result-timing data consumed by the pipeline's forwarding/stall controller. Each cycle it accepts the decoded source/destination register numbers, write enable and Tnew of the instruction in D. It carries them through the E, M and W pipeline registers, with Tnew aging per stage. It also turns the controller's Stall back into PC/FD hold and DE bubble controls.

## Interface
Parameters:
- `TNEW_W`, 3, width of Tnew fields
- `CNT_W`, 32, width of stall statistics counter (only with `HAZARD_STATS_EN`)

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `A1D`  in  5  rs of instruction in D
- `A2D`  in  5  rt of instruction in D
- `A3D`  in  5  destination register of instruction in D
- `WED`  in  1  instruction in D writes the GRF
- `TnewD`  in  TNEW_W  cycles after entering E until result exists (ALU 1, load 2, jal/lui 0)
- `Stall`  in  1  stall request from forwarding/stall controller
- `A1E`, `A2E`, `A3E`  out  5 each  E-stage register numbers
- `WEE`  out  1  E-stage write enable
- `TnewE`  out  TNEW_W  E-stage Tnew
- `A2M`, `A3M`  out  5 each  M-stage register numbers
- `WEM`  out  1  M-stage write enable
- `TnewM`  out  TNEW_W  M-stage Tnew
- `A3W`  out  5  W-stage destination
- `WEW`  out  1  W-stage write enable
- `EnPC`, `EnFD`  out  1 each  PC / FD register enables
- `ClrDE`  out  1  DE register synchronous clear
- `StallCnt`  out  CNT_W  stall cycles since reset (only with `HAZARD_STATS_EN`)

## Operation
- Three register stages: DE, EM and MW, all updated on the rising `clk` edge.
- DE update:
  - `Stall`=1: load bubble (all fields 0, `WEE`=0, `TnewE`=0).
  - Otherwise: load the D inputs.
- Write-enable normalisation at DE load: stored WE = `WED` && (`A3D`≠0). A bubble or a $0 write never asserts any WE.
- EM update:
  - Always advances; never held and never cleared by `Stall`.
  - `TnewM` = `TnewE`−1, saturating at 0 (`TnewE`=0 → 0).
- MW update:
  - Always advances.
  - Copies `A3M`/`WEM` to `A3W`/`WEW`.
  - W has no Tnew; it is implicitly 0.
- Control outputs, combinational from `Stall` only:
  - `EnPC` = `EnFD` = ~`Stall`
  - `ClrDE` = `Stall`
- `A1D`/`A2D`/`A3D` with value 0 pass through unchanged; only WE is masked.
- No internal hazard detection. A `Stall` held for N cycles inserts exactly N bubbles.

## Timing
- Reset, asynchronous, immediate: every stage register goes to 0, so all `A*`, `WE*`, `Tnew*` outputs are 0 and `StallCnt`=0.
- Control outputs during reset: `EnPC`/`EnFD`/`ClrDE` still follow `Stall`.
- Latency: a D instruction appears on E outputs 1 cycle after the edge that accepts it, on M after 2, on W after 3.
- Reset asserted mid-stream clears all in-flight entries. The first post-reset edge with `Stall`=0 loads D normally.
- `Stall` sampled at the edge; no registered copy of `Stall` is kept.
- `Stall` and a D-stage $0 destination together: a bubble is loaded (bubble wins).

## Configuration
- `HAZARD_STATS_EN` defined:
  - `StallCnt` port exists.
  - Counter increments on every edge where `Stall`=1, wraps modulo 2^CNT_W, and resets to 0.
- Undefined: the `StallCnt` port and the counter are absent; all other behaviour is identical.

## Structure
- Shared package (or `define header):
  - register-number width (5)
  - `TNEW_W`
  - named Tnew constants `TNEW_ALU`=1, `TNEW_LOAD`=2, `TNEW_ZERO`=0
  - these are shared with the decoder and the forwarding/stall controller
- One sub-module, `hazard_stage_reg`: parameterised clear/load register for {A1,A2,A3,WE,Tnew}, instantiated three times; unused fields are optimised away per stage.

## Test plan
- Reset with `A3D`=5, `WED`=1, `TnewD`=2 driven → all outputs 0. Release, no stall → after 1 edge `A3E`=5/`WEE`=1/`TnewE`=2; edge 2 `A3M`=5/`TnewM`=1; edge 3 `A3W`=5/`WEW`=1.
- `A3D`=0, `WED`=1 → `WEE`=0 next cycle; `WEM` and `WEW` stay 0 as it advances.
- `Stall`=1 for 2 cycles with load (`A3D`=8, `TnewD`=2) in D → E shows 2 bubbles (`WEE`=0); the older instruction continues into M/W unaffected; `EnPC`=`EnFD`=0 and `ClrDE`=1 while stalled.
- `TnewD`=0 (jal, `A3D`=31) → `TnewE`=0, then `TnewM`=0 (saturation, no underflow to 7).
- Reset asserted mid-pipeline with 3 valid entries → all outputs 0 immediately, before the next `clk` edge.
- With `HAZARD_STATS_EN` and CNT_W=4: 17 stall cycles → `StallCnt`=1 (wrap); reset → 0.
